// File: rtl/snn_bus_pkg.sv
// Shared definitions for the neuron-to-MAC spike address bus.
// MAC receivers use the same address width and idle code.
package snn_bus_pkg;

   localparam int ADDR_BITS = 12;
   localparam logic [ADDR_BITS-1:0] IDLE_ADDR = 12'hFFF;

   localparam int DEF_NUM_NEURONS = 10;
   localparam int CNT_BITS = $clog2(DEF_NUM_NEURONS + 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SEND,
      ST_CLEAR
   } disp_state_t;

   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/lowest_set_index.sv
// Priority encoder: index of the lowest set bit and a non-empty flag.
module lowest_set_index #(
   parameter int NUM_NEURONS = 10,
   parameter int IW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
   input  logic [NUM_NEURONS-1:0] vec,
   output logic [IW-1:0]          idx,
   output logic                   any
);

   always_comb begin
      idx = '0;
      any = 1'b0;
      for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
         if (vec[i]) begin
            idx = IW'(i);
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/spike_dispatcher.sv
// Serializes a latched spike vector onto the source-address bus,
// lowest index first, then drives the timestep-end clear level.
module spike_dispatcher #(
   parameter int NUM_NEURONS = 10,
   parameter int ADDR_BITS = snn_bus_pkg::ADDR_BITS,
   parameter logic [ADDR_BITS-1:0] BASE_ADDR = '0,
   parameter logic [ADDR_BITS-1:0] IDLE_ADDR = snn_bus_pkg::IDLE_ADDR,
   parameter int CLEAR_CYCLES = 2
) (
   input  logic                               CLK,
   input  logic                               RST,
   input  logic [NUM_NEURONS-1:0]             spikes_in,
   input  logic                               spikes_valid,
   input  logic                               addr_ready,
   output logic [ADDR_BITS-1:0]               source_address,
   output logic                               addr_valid,
   output logic                               clear,
   output logic                               timestep_done,
   output logic                               busy,
   output logic [$clog2(NUM_NEURONS+1)-1:0]   spike_count,
   output logic                               overflow
);

   import snn_bus_pkg::*;

   localparam int CW = $clog2(NUM_NEURONS + 1);
   localparam int IW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
   localparam int KW = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
   localparam logic [KW-1:0] CLR_LAST = KW'(CLEAR_CYCLES - 1);
   localparam logic [KW-1:0] CLR_PRE =
      KW'((CLEAR_CYCLES > 1) ? CLEAR_CYCLES - 2 : 0);

   disp_state_t state;
   logic [NUM_NEURONS-1:0] pending;
   logic [NUM_NEURONS-1:0] vec_n;
   logic [IW-1:0] cur_idx;
   logic [IW-1:0] idx_n;
   logic any_n;
   logic xfer;
   logic [CW-1:0] run_cnt;
   logic [CW-1:0] run_n;
   logic [KW-1:0] clr_cnt;
   logic [ADDR_BITS-1:0] addr_n;

   // Vector as it will stand after this edge; the encoder looks one step ahead
   // so the address and valid outputs can be registered.
   always_comb begin
      xfer = (state == ST_SEND) && addr_valid && addr_ready;
      vec_n = pending;
      if (state == ST_IDLE) begin
         vec_n = spikes_in;
      end else if (xfer) begin
         vec_n[cur_idx] = 1'b0;
      end
      run_n = run_cnt + CW'(xfer);
   end

   lowest_set_index #(
      .NUM_NEURONS(NUM_NEURONS),
      .IW(IW)
   ) u_lsi (
      .vec(vec_n),
      .idx(idx_n),
      .any(any_n)
   );

   assign addr_n = BASE_ADDR + ADDR_BITS'(idx_n);
   assign busy = (state != ST_IDLE);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= ST_IDLE;
         pending <= '0;
         cur_idx <= '0;
         run_cnt <= '0;
         clr_cnt <= '0;
         source_address <= IDLE_ADDR;
         addr_valid <= 1'b0;
         clear <= 1'b0;
         timestep_done <= 1'b0;
         spike_count <= '0;
         overflow <= 1'b0;
      end else begin
         timestep_done <= 1'b0;
         overflow <= spikes_valid && (state != ST_IDLE);
         unique case (state)
            ST_IDLE: begin
               if (spikes_valid) begin
                  state <= ST_SEND;
                  pending <= vec_n;
                  run_cnt <= '0;
                  cur_idx <= idx_n;
                  addr_valid <= any_n;
                  source_address <= any_n ? addr_n : IDLE_ADDR;
               end
            end
            ST_SEND: begin
               if (!addr_valid || xfer) begin
                  pending <= vec_n;
                  run_cnt <= run_n;
                  cur_idx <= idx_n;
                  addr_valid <= any_n;
                  source_address <= any_n ? addr_n : IDLE_ADDR;
                  if (!any_n) begin
                     state <= ST_CLEAR;
                     clear <= 1'b1;
                     clr_cnt <= '0;
                     if (CLEAR_CYCLES == 1) begin
                        timestep_done <= 1'b1;
                        spike_count <= run_n;
                     end
                  end
               end
            end
            ST_CLEAR: begin
               if (clr_cnt == CLR_LAST) begin
                  state <= ST_IDLE;
                  clear <= 1'b0;
               end else begin
                  clr_cnt <= clr_cnt + 1'b1;
                  if (clr_cnt == CLR_PRE) begin
                     timestep_done <= 1'b1;
                     spike_count <= run_cnt;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spike_dispatcher.sv
// Directed bench for spike_dispatcher: vector table plus
// hand sequences for reset, backpressure, overflow and wrap.
module tb_spike_dispatcher;

   logic CLK = 1'b0;
   logic RST;
   logic [9:0] spikes_in;
   logic spikes_valid;
   logic addr_ready;

   logic [11:0] a1, a2;
   logic v1, v2, c1, c2, d1, d2, b1, b2, o1, o2;
   logic [3:0] n1, n2;

   always #5 CLK = ~CLK;

   spike_dispatcher dut (
      .CLK(CLK), .RST(RST),
      .spikes_in(spikes_in), .spikes_valid(spikes_valid),
      .addr_ready(addr_ready),
      .source_address(a1), .addr_valid(v1), .clear(c1),
      .timestep_done(d1), .busy(b1), .spike_count(n1),
      .overflow(o1)
   );

   spike_dispatcher #(.BASE_ADDR(12'hFFE)) dut2 (
      .CLK(CLK), .RST(RST),
      .spikes_in(spikes_in), .spikes_valid(spikes_valid),
      .addr_ready(addr_ready),
      .source_address(a2), .addr_valid(v2), .clear(c2),
      .timestep_done(d2), .busy(b2), .spike_count(n2),
      .overflow(o2)
   );

   logic which;
   wire [11:0] m_addr = which ? a2 : a1;
   wire m_valid = which ? v2 : v1;
   wire m_clear = which ? c2 : c1;
   wire m_done = which ? d2 : d1;
   wire m_busy = which ? b2 : b1;
   wire m_ovf = which ? o2 : o1;
   wire [3:0] m_cnt = which ? n2 : n1;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [9:0] spikes;
      int n;
      int addr[10];
   } vec_t;

   vec_t tbl[6];

   int got[16];
   int got_n, clr_n, clr_c, done_n, done_c, cnt_done;
   int ovf_n, stall_n, hold_bad, idle_bad, first_v, a0;

   task automatic chk(input string nm, input int g, input int e);
      tests++;
      if (g != e) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", nm, g, e);
      end
   endtask

   task automatic run_ts(input logic [9:0] v, input int stall,
                         input int ovf_at);
      got_n = 0; clr_n = 0; clr_c = -1; done_n = 0; done_c = -1;
      cnt_done = -1; ovf_n = 0; stall_n = 0; hold_bad = 0;
      idle_bad = 0; a0 = -1;
      for (int i = 0; i < 16; i++) got[i] = -1;
      spikes_in = v;
      spikes_valid = 1'b1;
      addr_ready = 1'b1;
      @(posedge CLK); #1;
      first_v = int'(m_valid);
      for (int c = 0; c < 30; c++) begin
         spikes_valid = (c == ovf_at);
         if (c == ovf_at) spikes_in = ~v;
         addr_ready = (c >= stall);
         if (c == 0) a0 = int'(m_addr);
         if (m_valid && !addr_ready) begin
            stall_n++;
            if (int'(m_addr) != a0) hold_bad++;
         end
         if (!m_valid && m_addr !== 12'hFFF) idle_bad++;
         if (m_clear) begin
            clr_n++;
            if (clr_c < 0) clr_c = c;
         end
         if (m_done) begin
            done_n++;
            done_c = c;
            cnt_done = int'(m_cnt);
         end
         if (m_ovf) ovf_n++;
         if (m_valid && addr_ready && got_n < 16) begin
            got[got_n] = int'(m_addr);
            got_n++;
         end
         @(posedge CLK); #1;
      end
      spikes_valid = 1'b0;
      addr_ready = 1'b1;
   endtask

   task automatic verify(input string nm, input int n, input int ea[10],
                         input int stall, input int eovf);
      int ec;
      ec = (n == 0) ? 1 : n + stall;
      chk({nm, " latency"}, first_v, (n > 0) ? 1 : 0);
      chk({nm, " n_addr"}, got_n, n);
      for (int i = 0; i < n; i++)
         chk($sformatf("%s addr%0d", nm, i), got[i], ea[i]);
      chk({nm, " clear_start"}, clr_c, ec);
      chk({nm, " clear_len"}, clr_n, 2);
      chk({nm, " done_n"}, done_n, 1);
      chk({nm, " done_cyc"}, done_c, ec + 1);
      chk({nm, " count"}, cnt_done, n);
      chk({nm, " overflow"}, ovf_n, eovf);
      chk({nm, " idle_addr"}, idle_bad, 0);
      chk({nm, " busy_end"}, int'(m_busy), 0);
   endtask

   initial begin
      int ev[10];
      int k;
      tbl[0] = '{10'b0000000111, 3, '{0, 1, 2, 0, 0, 0, 0, 0, 0, 0}};
      tbl[1] = '{10'b1000000001, 2, '{0, 9, 0, 0, 0, 0, 0, 0, 0, 0}};
      tbl[2] = '{10'b0101010100, 4, '{2, 4, 6, 8, 0, 0, 0, 0, 0, 0}};
      tbl[3] = '{10'b1111111111, 10, '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9}};
      tbl[4] = '{10'b0000000000, 0, '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0}};
      tbl[5] = '{10'b1000000000, 1, '{9, 0, 0, 0, 0, 0, 0, 0, 0, 0}};

      which = 1'b0;
      RST = 1'b1;
      spikes_in = '0;
      spikes_valid = 1'b0;
      addr_ready = 1'b0;
      #12;
      chk("rst addr", int'(m_addr), 12'hFFF);
      chk("rst valid", int'(m_valid), 0);
      chk("rst clear", int'(m_clear), 0);
      chk("rst done", int'(m_done), 0);
      chk("rst busy", int'(m_busy), 0);
      chk("rst count", int'(m_cnt), 0);
      chk("rst ovf", int'(m_ovf), 0);
      @(posedge CLK); #1;
      RST = 1'b0;
      @(posedge CLK); #1;

      for (int t = 0; t < 6; t++) begin
         run_ts(tbl[t].spikes, 0, -1);
         verify($sformatf("vec%0d", t), tbl[t].n, tbl[t].addr, 0, 0);
      end

      ev = '{0, 9, 0, 0, 0, 0, 0, 0, 0, 0};
      run_ts(10'b1000000001, 3, -1);
      verify("bp", 2, ev, 3, 0);
      chk("bp stall_n", stall_n, 3);
      chk("bp hold", hold_bad, 0);
      repeat (3) @(posedge CLK);
      #1;
      chk("bp count_hold", int'(m_cnt), 2);

      ev = '{0, 1, 2, 0, 0, 0, 0, 0, 0, 0};
      run_ts(10'b0000000111, 0, 1);
      verify("ovf", 3, ev, 0, 1);

      which = 1'b1;
      ev = '{12'hFFE, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      run_ts(10'b0000000101, 0, -1);
      verify("wrap", 2, ev, 0, 0);
      which = 1'b0;

      spikes_in = 10'b0000000111;
      spikes_valid = 1'b1;
      addr_ready = 1'b1;
      @(posedge CLK); #1;
      spikes_valid = 1'b0;
      chk("rsend first", int'(m_addr), 0);
      @(posedge CLK); #1;
      chk("rsend second", int'(m_addr), 1);
      RST = 1'b1;
      #1;
      chk("rsend valid", int'(m_valid), 0);
      chk("rsend clear", int'(m_clear), 0);
      chk("rsend addr", int'(m_addr), 12'hFFF);
      chk("rsend busy", int'(m_busy), 0);
      @(posedge CLK); #1;
      RST = 1'b0;
      k = 0;
      for (int c = 0; c < 10; c++) begin
         if (m_done || m_valid || m_clear) k++;
         @(posedge CLK); #1;
      end
      chk("rsend quiet", k, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/spike_dispatcher.md
Name: spike_dispatcher

Overview:
Transmit side of the neuron-to-MAC spike address bus. Latches one timestep's spike vector from the neuron array and serializes every set bit onto a 12-bit source-address bus, lowest index first, with valid/ready handshaking. After the last address it drives the timestep-end clear level that MAC units use to fold their incoming spikes into the weighted sum. It sits between the neuron layer outputs and the broadcast input of all mac units.

Parameters:
NUM_NEURONS, 10, width of the spike vector and number of addressable sources
ADDR_BITS, 12, source address width
BASE_ADDR, 0, address emitted for neuron index 0; index i emits BASE_ADDR+i
IDLE_ADDR, 12'hFFF, address driven while no address is valid; must match no configured source
CLEAR_CYCLES, 2, number of cycles the clear output is held high at timestep end (minimum 1)

Ports:
CLK  in  1  system clock, all state on rising edge
RST  in  1  asynchronous, active-high reset
spikes_in  in  NUM_NEURONS  spike flags from neuron layer, sampled only on spikes_valid
spikes_valid  in  1  one-cycle pulse: end of neuron update, latch spikes_in
addr_ready  in  1  receiver accepts source_address this cycle
source_address  out  ADDR_BITS  current spike source address
addr_valid  out  1  source_address carries a real spike
clear  out  1  timestep-end level to MAC units
timestep_done  out  1  one-cycle pulse on the last clear cycle
busy  out  1  high in any state other than IDLE
spike_count  out  clog2(NUM_NEURONS+1)  addresses sent in the completed timestep, valid from timestep_done onward
overflow  out  1  one-cycle pulse: spikes_valid arrived while busy, vector dropped

Behaviour:
- Interface: one clock (CLK); reset RST is asynchronous and active-high.
- Reset values: source_address=IDLE_ADDR, addr_valid=0, clear=0, timestep_done=0, busy=0, spike_count=0, overflow=0, pending vector=0, state IDLE. Reset mid-SEND or mid-CLEAR aborts immediately with no further addresses and no clear.
- FSM states: IDLE, SEND, CLEAR.
- IDLE: on spikes_valid, latch spikes_in into the pending vector, zero the running count, go to SEND. Latency: first addr_valid is high the cycle after spikes_valid.
- SEND: addr_valid=1 and source_address=BASE_ADDR+lowest set index whenever the pending vector is nonzero. Handshake: transfer occurs on a rising edge with addr_valid and addr_ready both high. On transfer, clear that bit, increment the running count, and present the next lowest index on the next cycle (one address per cycle at full throughput). While addr_ready=0, source_address and addr_valid hold stable. When the vector is empty, addr_valid=0, source_address=IDLE_ADDR, go to CLEAR.
- Empty vector latched: SEND is occupied for exactly one cycle with addr_valid=0, then CLEAR. The timestep still ends.
- CLEAR: clear=1 for exactly CLEAR_CYCLES cycles. addr_valid=0 and source_address=IDLE_ADDR throughout. On the final cycle, timestep_done=1 and spike_count is updated from the running count. Then return to IDLE with clear=0.
- spike_count holds until the next timestep_done.
- Address arithmetic: BASE_ADDR+index truncated to ADDR_BITS (wraps modulo 2^ADDR_BITS).
- spikes_valid in SEND or CLEAR: input is ignored, overflow pulses for one cycle, and the current timestep is unaffected. spikes_valid in the same cycle the FSM enters IDLE is accepted.
- addr_ready is ignored outside SEND.

Decomposition:
- Shared package snn_bus_pkg holds: ADDR_BITS, IDLE_ADDR, the FSM state encoding, and a clog2-derived count width constant. MAC units use the same ADDR_BITS/IDLE_ADDR.
- One sub-module, lowest_set_index: combinational priority encoder (vector -> index + any flag), parameterized by NUM_NEURONS.

Test Plan:
- Reset mid-SEND: latch 10'b0000000111, assert RST after the first transfer -> addr_valid=0 and clear=0 asynchronously, source_address=12'hFFF; no timestep_done after release.
- Full throughput: spikes_in=10'b0000000111, addr_ready=1 -> addresses 0,1,2 on three consecutive cycles starting one cycle after spikes_valid; clear high 2 cycles; timestep_done on the second; spike_count=3.
- Backpressure: spikes_in=10'b1000000001, addr_ready low 3 cycles while address 0 is shown -> address 0 held stable 4 cycles, then 9; spike_count=2.
- Empty vector: spikes_in=0 -> no addr_valid; clear high from cycle t+2 for 2 cycles; spike_count=0.
- Overflow: spikes_valid during SEND with a new vector -> overflow pulses 1 cycle; only the original addresses are emitted.
- Wrap and base: BASE_ADDR=12'hFFE, spikes_in=10'b0000000101 -> addresses 12'hFFE then 12'h000; all-ones vector -> 10 addresses, spike_count=10.
